// File: rtl/clock_time_set_ctrl.sv
// Button-driven time-set editor: debounces mode/inc/dec and edits hours -> minutes -> AM/PM for the clock counter.
// Latency: raw button edge -> press event DEBOUNCE_CYCLES+1 clocks; mode press in AM/PM field -> load one cycle later.
// Backpressure: none; ena_i=0 freezes every register, and hold_o tells the counter to stop while editing.
//
// Ports:
//   clk_i, rst_i (sync, active-high), ena_i        clock, reset, global enable
//   sec_tick_i                                      1 Hz one-cycle strobe
//   btn_mode_i, btn_inc_i, btn_dec_i                raw synchronised buttons, active-high
//   cur_hours_i, cur_minutes_i, cur_am_pm_i         live counter time
//   hold_o, load_o                                  counter hold / one-cycle load strobe
//   ld_hours_o, ld_minutes_o, ld_am_pm_o            edited time presented with load_o
//   edit_field_o, blink_o                           display cues: field being edited and its blink phase
module clock_time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 10_000,
    parameter int TIMEOUT_SEC     = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ena_i,
    input  logic       sec_tick_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic       btn_dec_i,
    input  logic [3:0] cur_hours_i,
    input  logic [5:0] cur_minutes_i,
    input  logic       cur_am_pm_i,
    output logic       hold_o,
    output logic       load_o,
    output logic [3:0] ld_hours_o,
    output logic [5:0] ld_minutes_o,
    output logic       ld_am_pm_o,
    output logic [1:0] edit_field_o,
    output logic       blink_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_SEC + 1);

    typedef enum logic [2:0] {
        S_RUN,
        S_E_HR,
        S_E_MIN,
        S_E_AP,
        S_COMMIT
    } state_t;

    // ------------------------------------------------------------------
    // Debounce: bit 0 = mode, bit 1 = inc, bit 2 = dec
    // ------------------------------------------------------------------
    logic [2:0] raw_btn;
    logic [2:0] press;

    assign raw_btn = {btn_dec_i, btn_inc_i, btn_mode_i};

    for (genvar i = 0; i < 3; i++) begin : g_db
        logic [CW-1:0] cnt_q;
        logic          stable_q;
        logic          press_q;

        // The press pulse is registered on the same edge the stable value
        // rises, so the editor consumes it DEBOUNCE_CYCLES+1 edges after
        // the raw edge. A falling stable value never raises press_q.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
                press_q  <= 1'b0;
            end else if (ena_i) begin
                press_q <= 1'b0;
                if (raw_btn[i] == stable_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_q    <= '0;
                    stable_q <= raw_btn[i];
                    press_q  <= raw_btn[i];
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end

        assign press[i] = press_q;
    end

    logic mode_ev, inc_ev, dec_ev, any_ev;
    assign mode_ev = press[0];
    assign inc_ev  = press[1];
    assign dec_ev  = press[2];
    assign any_ev  = mode_ev | inc_ev | dec_ev;

    // ------------------------------------------------------------------
    // Field editor FSM with registered outputs
    // ------------------------------------------------------------------
    state_t        state_q;
    logic          hold_q;
    logic          load_q;
    logic          blink_q;
    logic [1:0]    field_q;
    logic [3:0]    ld_hours_q;
    logic [5:0]    ld_minutes_q;
    logic          ld_am_pm_q;
    logic [TW-1:0] tmo_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_RUN;
            hold_q       <= 1'b0;
            load_q       <= 1'b0;
            blink_q      <= 1'b0;
            field_q      <= 2'd0;
            ld_hours_q   <= 4'd12;
            ld_minutes_q <= 6'd0;
            ld_am_pm_q   <= 1'b0;
            tmo_q        <= '0;
        end else if (ena_i) begin
            load_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (mode_ev) begin
                        state_q      <= S_E_HR;
                        hold_q       <= 1'b1;
                        field_q      <= 2'd1;
                        blink_q      <= 1'b1;
                        ld_hours_q   <= cur_hours_i;
                        ld_minutes_q <= cur_minutes_i;
                        ld_am_pm_q   <= cur_am_pm_i;
                        tmo_q        <= '0;
                    end
                end

                S_E_HR, S_E_MIN, S_E_AP: begin
                    if (any_ev) begin
                        tmo_q <= '0;
                        if (sec_tick_i) begin
                            blink_q <= ~blink_q;
                        end
                        if (mode_ev) begin
                            // mode outranks any inc/dec in the same cycle
                            case (state_q)
                                S_E_HR: begin
                                    state_q <= S_E_MIN;
                                    field_q <= 2'd2;
                                end
                                S_E_MIN: begin
                                    state_q <= S_E_AP;
                                    field_q <= 2'd3;
                                end
                                default: begin
                                    state_q <= S_COMMIT;
                                    field_q <= 2'd0;
                                    blink_q <= 1'b0;
                                    load_q  <= 1'b1;
                                end
                            endcase
                        end else if (inc_ev ^ dec_ev) begin
                            case (state_q)
                                S_E_HR: begin
                                    if (inc_ev) begin
                                        ld_hours_q <= (ld_hours_q == 4'd12) ? 4'd1 : ld_hours_q + 4'd1;
                                    end else begin
                                        ld_hours_q <= (ld_hours_q == 4'd1) ? 4'd12 : ld_hours_q - 4'd1;
                                    end
                                end
                                S_E_MIN: begin
                                    if (inc_ev) begin
                                        ld_minutes_q <= (ld_minutes_q == 6'd59) ? 6'd0 : ld_minutes_q + 6'd1;
                                    end else begin
                                        ld_minutes_q <= (ld_minutes_q == 6'd0) ? 6'd59 : ld_minutes_q - 6'd1;
                                    end
                                end
                                default: begin
                                    ld_am_pm_q <= ~ld_am_pm_q;
                                end
                            endcase
                        end
                    end else if (sec_tick_i) begin
                        if (tmo_q == TW'(TIMEOUT_SEC - 1)) begin
                            // abandon the edit; ld_* keep the edited values but no load
                            state_q <= S_RUN;
                            hold_q  <= 1'b0;
                            field_q <= 2'd0;
                            blink_q <= 1'b0;
                            tmo_q   <= '0;
                        end else begin
                            tmo_q   <= tmo_q + TW'(1);
                            blink_q <= ~blink_q;
                        end
                    end
                end

                S_COMMIT: begin
                    // load_q was raised on entry and drops by default this edge
                    state_q <= S_RUN;
                    hold_q  <= 1'b0;
                    tmo_q   <= '0;
                end

                default: begin
                    state_q <= S_RUN;
                    hold_q  <= 1'b0;
                    field_q <= 2'd0;
                    blink_q <= 1'b0;
                    tmo_q   <= '0;
                end
            endcase
        end
    end

    assign hold_o       = hold_q;
    assign load_o       = load_q;
    assign blink_o      = blink_q;
    assign edit_field_o = field_q;
    assign ld_hours_o   = ld_hours_q;
    assign ld_minutes_o = ld_minutes_q;
    assign ld_am_pm_o   = ld_am_pm_q;

endmodule

// File: tb/tb_clock_time_set_ctrl.sv
// Bench for clock_time_set_ctrl: directed scenarios followed by random button/tick traffic.
// Latency: expected loads are queued when the commit press is issued and popped by a monitor on load_o.
// Backpressure: none; the bench also exercises ena_i freezes and mid-edit resets.
module tb_clock_time_set_ctrl;

    localparam int D = 4;
    localparam int T = 3;

    logic       clk = 1'b0;
    logic       rst, ena, sec_tick, bm, bi, bd;
    logic [3:0] cur_h;
    logic [5:0] cur_m;
    logic       cur_ap;
    logic       hold_o, load_o, ld_am_pm_o, blink_o;
    logic [3:0] ld_hours_o;
    logic [5:0] ld_minutes_o;
    logic [1:0] edit_field_o;

    always #5 clk = ~clk;

    clock_time_set_ctrl #(.DEBOUNCE_CYCLES(D), .TIMEOUT_SEC(T)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ena_i        (ena),
        .sec_tick_i   (sec_tick),
        .btn_mode_i   (bm),
        .btn_inc_i    (bi),
        .btn_dec_i    (bd),
        .cur_hours_i  (cur_h),
        .cur_minutes_i(cur_m),
        .cur_am_pm_i  (cur_ap),
        .hold_o       (hold_o),
        .load_o       (load_o),
        .ld_hours_o   (ld_hours_o),
        .ld_minutes_o (ld_minutes_o),
        .ld_am_pm_o   (ld_am_pm_o),
        .edit_field_o (edit_field_o),
        .blink_o      (blink_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_loads = 0;

    typedef struct {
        int h;
        int m;
        int ap;
    } ld_t;
    ld_t exp_q[$];

    // Reference model: which field is being edited (0 = none), edited time,
    // seconds since last press, blink phase.
    int m_field, m_h, m_m, m_ap, m_ticks, m_blink;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every cycle load_o is high must match the oldest queued commit.
    always @(negedge clk) begin : mon
        ld_t e;
        if (rst === 1'b0 && load_o === 1'b1) begin
            n_loads++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_load: got load=1 expected no load (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                chk("load_hours", int'(ld_hours_o), e.h);
                chk("load_minutes", int'(ld_minutes_o), e.m);
                chk("load_am_pm", int'(ld_am_pm_o), e.ap);
                chk("load_hold", int'(hold_o), 1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_field = 0; m_h = 12; m_m = 0; m_ap = 0; m_ticks = 0; m_blink = 0;
    endtask

    task automatic model_press(input bit mo, input bit in, input bit de);
        ld_t e;
        if (m_field == 0) begin
            if (mo) begin
                m_field = 1; m_blink = 1; m_ticks = 0;
                m_h = int'(cur_h); m_m = int'(cur_m); m_ap = int'(cur_ap);
            end
        end else begin
            m_ticks = 0;
            if (mo) begin
                if (m_field == 3) begin
                    e.h = m_h; e.m = m_m; e.ap = m_ap;
                    exp_q.push_back(e);
                    m_field = 0; m_blink = 0;
                end else begin
                    m_field++;
                end
            end else if (in != de) begin
                case (m_field)
                    1: m_h  = in ? (m_h % 12) + 1 : ((m_h + 10) % 12) + 1;
                    2: m_m  = in ? (m_m + 1) % 60 : (m_m + 59) % 60;
                    default: m_ap = 1 - m_ap;
                endcase
            end
        end
    endtask

    task automatic model_tick();
        if (m_field != 0) begin
            m_ticks++;
            if (m_ticks == T) begin
                m_field = 0; m_ticks = 0; m_blink = 0;
            end else begin
                m_blink = 1 - m_blink;
            end
        end
    endtask

    // Full debounced press: held long enough to register, then released long
    // enough for the stable value to fall again.
    task automatic press(input bit mo, input bit in, input bit de);
        model_press(mo, in, de);
        bm = mo; bi = in; bd = de;
        step(D + 1);
        bm = 1'b0; bi = 1'b0; bd = 1'b0;
        step(D + 2);
    endtask

    task automatic tick();
        model_tick();
        sec_tick = 1'b1;
        step(1);
        sec_tick = 1'b0;
        step(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        model_reset();
        step(1);
    endtask

    task automatic check_state();
        @(negedge clk);
        chk("edit_field", int'(edit_field_o), m_field);
        chk("hold", int'(hold_o), (m_field != 0) ? 1 : 0);
        chk("blink", int'(blink_o), m_blink);
        chk("ld_hours", int'(ld_hours_o), m_h);
        chk("ld_minutes", int'(ld_minutes_o), m_m);
        chk("ld_am_pm", int'(ld_am_pm_o), m_ap);
        chk("load_idle", int'(load_o), 0);
        step(1);
    endtask

    initial begin
        int loads_before;
        int r;
        rst = 1'b1; ena = 1'b1; sec_tick = 1'b0;
        bm = 1'b0; bi = 1'b0; bd = 1'b0;
        cur_h = 4'd12; cur_m = 6'd0; cur_ap = 1'b0;
        step(3);
        rst = 1'b0;
        model_reset();
        step(1);

        // Reset state
        check_state();

        // Short glitch on mode is filtered out
        bm = 1'b1; step(3); bm = 1'b0; step(D + 3);
        check_state();

        // Clean mode press -> hours field, live time copied
        press(1, 0, 0);
        check_state();

        // Hour and minute wrap
        press(0, 1, 0);
        chk("hours_wrap_up", int'(ld_hours_o), 1);
        press(0, 0, 1);
        chk("hours_wrap_down", int'(ld_hours_o), 12);
        press(1, 0, 0);
        press(0, 0, 1);
        chk("minutes_wrap_down", int'(ld_minutes_o), 59);
        check_state();
        press(1, 0, 0);
        press(1, 0, 0);
        check_state();

        // Full edit from 03:15 PM
        cur_h = 4'd3; cur_m = 6'd15; cur_ap = 1'b1;
        loads_before = n_loads;
        press(1, 0, 0); press(0, 1, 0);
        press(1, 0, 0); press(0, 1, 0); press(0, 1, 0);
        press(1, 0, 0); press(0, 1, 0);
        press(1, 0, 0);
        chk("commit_load_count", n_loads - loads_before, 1);
        chk("commit_hours", int'(ld_hours_o), 4);
        chk("commit_minutes", int'(ld_minutes_o), 17);
        chk("commit_am_pm", int'(ld_am_pm_o), 0);
        check_state();

        // Timeout in minutes field, then a press restarting the count
        loads_before = n_loads;
        press(1, 0, 0); press(1, 0, 0);
        tick(); tick();
        check_state();
        tick();
        check_state();
        press(1, 0, 0); press(1, 0, 0);
        tick(); tick();
        press(0, 1, 0);
        tick(); tick();
        check_state();
        tick();
        check_state();
        chk("timeout_no_load", n_loads - loads_before, 0);

        // Same-cycle mode+inc, same-cycle inc+dec, reset mid-edit
        press(1, 0, 0);
        press(1, 1, 0);
        check_state();
        press(0, 1, 1);
        check_state();
        press(1, 0, 0);
        loads_before = n_loads;
        do_reset();
        check_state();

        // ena low freezes debounce and tick handling
        press(1, 0, 0);
        ena = 1'b0; bi = 1'b1; sec_tick = 1'b1;
        step(D + 3);
        bi = 1'b0; sec_tick = 1'b0;
        step(2);
        ena = 1'b1;
        step(1);
        check_state();
        chk("reset_no_load", n_loads - loads_before, 0);

        // Random traffic
        for (int k = 0; k < 250; k++) begin
            cur_h  = 4'($urandom_range(1, 12));
            cur_m  = 6'($urandom_range(0, 59));
            cur_ap = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 29);
            if (r < 7)       press(1, 0, 0);
            else if (r < 12) press(0, 1, 0);
            else if (r < 17) press(0, 0, 1);
            else if (r < 19) press(1, 1, 0);
            else if (r < 21) press(0, 1, 1);
            else if (r < 27) tick();
            else if (r < 29) begin
                ena = 1'b0; sec_tick = 1'b1; bm = 1'b1;
                step(D + 2);
                sec_tick = 1'b0; bm = 1'b0;
                step(1);
                ena = 1'b1;
                step(1);
            end else begin
                do_reset();
            end
            check_state();
        end

        step(5);
        chk("pending_loads", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
